rf_write_arbiter: RTL
=====================

Name: rf_write_arbiter

Overview:
Arbitrates the single register-file write port between the WB stage (in-order pipeline writeback) and a multicycle execution unit (mul/div class) that returns results out of band. The WB stage has priority. A one-entry hold buffer absorbs the multicycle result. A starvation counter raises a one-cycle pipeline freeze to force the buffered result in. It sits between the WB stage / multicycle unit and the register file, and its freeze output feeds the pipeline-register Freze network.

Parameters:
DATA_W, 16, register data width
ADDR_W, 4, register index width
MAX_WAIT, 4, consecutive lost cycles before forced freeze (>=1)

Ports:
clk  in  1  clock; all state updates on rising edge
rest  in  1  reset, asynchronous, active-high
wb_we  in  1  WB stage write request (RegWrite)
wb_rd  in  ADDR_W  WB destination register
wb_data  in  DATA_W  WB write data
mc_valid  in  1  multicycle result valid
mc_rd  in  ADDR_W  multicycle destination register
mc_data  in  DATA_W  multicycle result
mc_ready  out  1  arbiter can accept a multicycle result
rf_we  out  1  register-file write enable
rf_addr  out  ADDR_W  register-file write address
rf_data  out  DATA_W  register-file write data
freeze_out  out  1  pipeline freeze request (OR'd into Freze by parent)

Behaviour:
- State: buf_v, buf_rd, buf_data, cnt (width clog2(MAX_WAIT+1)), freeze_q. All reset to 0 asynchronously on rest=1.
- During reset, outputs are: rf_we=0, rf_addr=0, rf_data=0, freeze_out=0, mc_ready=1.
- mc_ready = !buf_v (combinational).
- Handshake: mc_valid && mc_ready at an edge loads buf_rd/buf_data and sets buf_v. The multicycle unit holds its data until the handshake completes.
- Grant, evaluated combinationally each cycle:
  - if freeze_q: grant the buffer if buf_v, else no grant; WB is blocked.
  - else if wb_we: grant WB.
  - else if buf_v: grant the buffer.
  - else no grant.
- Write port is combinational from the grant:
  - WB grant -> rf_we=1, rf_addr=wb_rd, rf_data=wb_data.
  - Buffer grant -> rf_we=1, rf_addr=buf_rd, rf_data=buf_data.
  - No grant -> rf_we=0, rf_addr=0, rf_data=0.
- Buffer grant clears buf_v at the edge. A new handshake is possible from the following cycle (mc_ready is 0 in the grant cycle).
- cnt:
  - increments (saturating at MAX_WAIT) when buf_v and the buffer is not granted;
  - clears when the buffer is granted or buf_v=0.
- freeze_q next = buf_v && !buffer_grant && (cnt == MAX_WAIT-1). So the freeze asserts in the cycle after the MAX_WAIT-th consecutive lost cycle.
- freeze_out = freeze_q (registered, glitch-free).
- Freeze lasts exactly one cycle, since the buffer is always granted in a freeze cycle.
- A WB request blocked by freeze is not lost: the frozen MEM2WB register re-presents it the next cycle. The arbiter does not store WB requests.
- Simultaneous wb_we and mc_valid with an empty buffer: WB is written that cycle and the MC result is captured into the buffer.
- Write-after-write ordering between WB and MC to the same rd is the issue scoreboard's responsibility, not this block's.
- Reset mid-operation discards the buffered result and any pending freeze, with no write after reset deasserts. The multicycle unit must be reset by the same rest.

Decomposition:
- Shared package: DATA_W/ADDR_W constants and the grant-source encoding (GNT_NONE, GNT_WB, GNT_BUF).
- No sub-module; the hold buffer plus starvation counter stays inline.

Test Plan:
1. Reset: assert rest mid-cycle (async) -> rf_we=0, rf_addr=0, rf_data=0, freeze_out=0, mc_ready=1 immediately.
2. MC alone: wb_we=0; mc_valid, rd=5, data=0x1234 at cycle N -> mc_ready=0 in N+1 with rf_we=1, addr=5, data=0x1234 in N+1; mc_ready=1 in N+2; freeze_out never 1.
3. WB priority: buffer holds rd=3/0x00AA; wb_we=1 rd=7 data=0x0BEE for 2 cycles then 0 -> two writes to 7, then write 3/0x00AA in cycle 3, freeze_out=0 throughout.
4. Starvation: MAX_WAIT=4, wb_we=1 continuously, buffer full at N -> WB written N..N+3; at N+4 freeze_out=1 and rf writes the buffer entry; freeze_out=0 at N+5 and WB resumes.
5. Simultaneous: empty buffer, wb_we=1 rd=2 and mc_valid rd=9 in the same cycle -> rd=2 written, MC accepted; next cycle with wb_we=0, rd=9 written.
6. Reset mid-starvation: cnt=2 with buffer full; pulse rest -> buf_v=0, freeze_out=0, no write of the old buffer entry after release.

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants and grant-source encoding for the register-file write
// arbiter.
//   RF_DATA_W   : default register data width
//   RF_ADDR_W   : default register index width
//   RF_MAX_WAIT : default number of consecutive lost cycles before a freeze
//   gnt_e       : which requester owns the write port this cycle
package rf_write_arbiter_pkg;

    localparam int RF_DATA_W   = 16;
    localparam int RF_ADDR_W   = 4;
    localparam int RF_MAX_WAIT = 4;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WB   = 2'd1,
        GNT_BUF  = 2'd2
    } gnt_e;

endpackage

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between the in-order WB
// stage (priority) and a multicycle unit whose result is parked in a one-entry
// hold buffer. A starvation counter raises a one-cycle freeze so the parked
// result is forced in after MAX_WAIT consecutive lost cycles.
//
// Ports:
//   clk        : clock, rising edge
//   rest       : asynchronous active-high reset
//   wb_we      : WB write request
//   wb_rd      : WB destination register
//   wb_data    : WB write data
//   mc_valid   : multicycle result valid
//   mc_rd      : multicycle destination register
//   mc_data    : multicycle result data
//   mc_ready   : hold buffer empty, a multicycle result can be accepted
//   rf_we      : register-file write enable
//   rf_addr    : register-file write address
//   rf_data    : register-file write data
//   freeze_out : registered pipeline freeze request
//
// Grant source | meaning
// GNT_NONE     | write port idle
// GNT_WB       | WB stage writes this cycle
// GNT_BUF      | hold buffer drains this cycle
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int MAX_WAIT = RF_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rest,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              mc_valid,
    input  logic [ADDR_W-1:0] mc_rd,
    input  logic [DATA_W-1:0] mc_data,
    output logic              mc_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data,
    output logic              freeze_out
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic              buf_v, buf_v_n;
    logic [ADDR_W-1:0] buf_rd, buf_rd_n;
    logic [DATA_W-1:0] buf_data, buf_data_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              freeze_q, freeze_n;
    gnt_e              gnt;
    logic              buf_lost;

    // State register
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            buf_v    <= 1'b0;
            buf_rd   <= '0;
            buf_data <= '0;
            cnt      <= '0;
            freeze_q <= 1'b0;
        end else begin
            buf_v    <= buf_v_n;
            buf_rd   <= buf_rd_n;
            buf_data <= buf_data_n;
            cnt      <= cnt_n;
            freeze_q <= freeze_n;
        end
    end

    // Grant and next-state
    always_comb begin
        gnt        = GNT_NONE;
        buf_v_n    = buf_v;
        buf_rd_n   = buf_rd;
        buf_data_n = buf_data;
        cnt_n      = '0;
        freeze_n   = 1'b0;

        // Gating on rest keeps the write port quiet while reset is held,
        // even if the WB stage still presents a request.
        if (rest)
            gnt = GNT_NONE;
        else if (freeze_q)
            gnt = buf_v ? GNT_BUF : GNT_NONE;
        else if (wb_we)
            gnt = GNT_WB;
        else if (buf_v)
            gnt = GNT_BUF;

        buf_lost = buf_v && (gnt != GNT_BUF);

        // mc_ready is !buf_v, so a handshake can only land in an empty buffer
        // and never collides with a drain in the same cycle.
        if (buf_v) begin
            if (gnt == GNT_BUF)
                buf_v_n = 1'b0;
        end else if (mc_valid) begin
            buf_v_n    = 1'b1;
            buf_rd_n   = mc_rd;
            buf_data_n = mc_data;
        end

        if (buf_lost) begin
            if (cnt != CNT_W'(MAX_WAIT))
                cnt_n = cnt + 1'b1;
            else
                cnt_n = cnt;
        end

        freeze_n = buf_lost && (cnt == CNT_W'(MAX_WAIT - 1));
    end

    // Outputs
    always_comb begin
        rf_we      = 1'b0;
        rf_addr    = '0;
        rf_data    = '0;
        mc_ready   = !buf_v;
        freeze_out = freeze_q;
        case (gnt)
            GNT_WB: begin
                rf_we   = 1'b1;
                rf_addr = wb_rd;
                rf_data = wb_data;
            end
            GNT_BUF: begin
                rf_we   = 1'b1;
                rf_addr = buf_rd;
                rf_data = buf_data;
            end
            default: ;
        endcase
    end

endmodule
